sd_phy_resp_rx: RTL and testbench

- Receive side of the SD command line (CMD) in the SD PHY.
- Once armed, waits for the card's response start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, and recomputes CRC7 bit-serially (polynomial x^7+x^3+1).
- Checks CRC and end bit; reports index, payload and status to the command controller with a single done pulse.
- Counterpart to the host command transmitter/CRC7 generator.

---
 rtl/sd_phy_resp_rx_if.sv | 34 +++
 rtl/sd_phy_resp_rx.sv | 156 +++++++++++++++
 tb/tb_sd_phy_resp_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_phy_resp_rx_if.sv
// Command-controller side of the SD CMD-line response receiver.
// master = command controller, slave = receiver.
// Optional SD_RESP_RX_R1B_EN adds wait_busy (sampled with start).
interface sd_phy_resp_rx_if;
  logic         start;
  logic         long_resp;
  logic         no_crc;
`ifdef SD_RESP_RX_R1B_EN
  logic         wait_busy;
`endif
  logic         busy;
  logic         done;
  logic         timeout;
  logic         crc_err;
  logic         end_err;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;

  modport master (
`ifdef SD_RESP_RX_R1B_EN
    output wait_busy,
`endif
    output start, long_resp, no_crc,
    input  busy, done, timeout, crc_err, end_err, resp_index, resp_data
  );

  modport slave (
`ifdef SD_RESP_RX_R1B_EN
    input  wait_busy,
`endif
    input  start, long_resp, no_crc,
    output busy, done, timeout, crc_err, end_err, resp_index, resp_data
  );
endinterface

// File: rtl/sd_phy_resp_rx.sv
// SD PHY CMD-line response receiver: waits for the start bit, shifts in a
// 48-bit or 136-bit (R2) response, recomputes CRC7 (x^7+x^3+1) bit-serially,
// checks CRC and end bit, and reports with a single done pulse.
// Optional macro SD_RESP_RX_R1B_EN: adds wait_busy/sd_dat0_i and a BUSY_WAIT
// state that holds off done until DAT0 is released after an R1b response.
module sd_phy_resp_rx #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic sd_cmd_i,
`ifdef SD_RESP_RX_R1B_EN
  input  logic sd_dat0_i,
`endif
  sd_phy_resp_rx_if.slave rx
);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, RECV, DONE
`ifdef SD_RESP_RX_R1B_EN
    , BUSY_WAIT
`endif
  } state_t;

  state_t             state, state_n;
  logic               long_q, nocrc_q;
`ifdef SD_RESP_RX_R1B_EN
  logic               wbusy_q;
`endif
  logic [CNT_W-1:0]   tmo_cnt, bit_cnt, bit_n;
  logic [6:0]         crc;
  logic [132:0]       sr;
  logic [133:0]       frame_w;
  logic [2:0]         cidx;
  logic               crc_feed, crc_chk;
  logic               timeout_q, crc_err_q, end_err_q;
  logic [5:0]         idx_q;
  logic [127:0]       data_q;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // bit_n is the frame position of the bit sampled on this strobe in RECV
  assign bit_n    = bit_cnt - CNT_W'(1);
  assign cidx     = bit_n[2:0] - 3'd1;
  assign frame_w  = {sr, sd_cmd_i};
  assign crc_feed = (bit_n >= CNT_W'(8)) && (!long_q || bit_n <= CNT_W'(127));
  assign crc_chk  = (bit_n >= CNT_W'(1)) && (bit_n <= CNT_W'(7));

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (rx.start) state_n = WAIT_START;
      WAIT_START: if (clk_en) begin
                    if (!sd_cmd_i)                    state_n = RECV;
                    else if (tmo_cnt == CNT_W'(1))    state_n = DONE;
                  end
      RECV:       if (clk_en && bit_cnt == CNT_W'(1)) begin
`ifdef SD_RESP_RX_R1B_EN
                    state_n = wbusy_q ? BUSY_WAIT : DONE;
`else
                    state_n = DONE;
`endif
                  end
`ifdef SD_RESP_RX_R1B_EN
      BUSY_WAIT:  if (clk_en && sd_dat0_i) state_n = DONE;
`endif
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // datapath: counters, shift register, CRC and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_q    <= 1'b0;
      nocrc_q   <= 1'b0;
`ifdef SD_RESP_RX_R1B_EN
      wbusy_q   <= 1'b0;
`endif
      tmo_cnt   <= '0;
      bit_cnt   <= '0;
      crc       <= '0;
      sr        <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: if (rx.start) begin
          long_q    <= rx.long_resp;
          nocrc_q   <= rx.no_crc;
`ifdef SD_RESP_RX_R1B_EN
          wbusy_q   <= rx.wait_busy;
`endif
          timeout_q <= 1'b0;
          crc_err_q <= 1'b0;
          end_err_q <= 1'b0;
          crc       <= '0;
          tmo_cnt   <= CNT_W'(NCR_MAX);
        end
        WAIT_START: if (clk_en) begin
          if (!sd_cmd_i) begin
            bit_cnt <= long_q ? CNT_W'(135) : CNT_W'(47);
            crc     <= crc7_step(crc, 1'b0);
            sr      <= {sr[131:0], 1'b0};
          end else begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
            if (tmo_cnt == CNT_W'(1)) timeout_q <= 1'b1;
          end
        end
        RECV: if (clk_en) begin
          sr      <= {sr[131:0], sd_cmd_i};
          bit_cnt <= bit_n;
          // R2 CRC covers only bits 127..8, so restart it at bit 127
          if (crc_feed)
            crc <= crc7_step((long_q && bit_n == CNT_W'(127)) ? 7'd0 : crc, sd_cmd_i);
          if (crc_chk && !nocrc_q && (sd_cmd_i != crc[cidx]))
            crc_err_q <= 1'b1;
          if (bit_n == '0) begin
            end_err_q <= ~sd_cmd_i;
            idx_q     <= long_q ? frame_w[133:128] : frame_w[45:40];
            data_q    <= long_q ? {frame_w[127:1], 1'b0} : {96'd0, frame_w[39:8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign rx.busy       = (state == WAIT_START) || (state == RECV)
`ifdef SD_RESP_RX_R1B_EN
                         || (state == BUSY_WAIT)
`endif
                         ;
  assign rx.done       = (state == DONE);
  assign rx.timeout    = timeout_q;
  assign rx.crc_err    = crc_err_q;
  assign rx.end_err    = end_err_q;
  assign rx.resp_index = idx_q;
  assign rx.resp_data  = data_q;

endmodule

// File: tb/tb_sd_phy_resp_rx.sv
// Scoreboard bench for sd_phy_resp_rx: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sd_phy_resp_rx;
  logic clk = 1'b0, reset = 1'b0, clk_en = 1'b0, sd_cmd_i = 1'b1;
`ifdef SD_RESP_RX_R1B_EN
  logic sd_dat0_i = 1'b1;
`endif
  int checks = 0, errors = 0;
  int gap = 3;

  sd_phy_resp_rx_if rif();

  sd_phy_resp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .sd_cmd_i (sd_cmd_i),
`ifdef SD_RESP_RX_R1B_EN
    .sd_dat0_i(sd_dat0_i),
`endif
    .rx       (rif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         to, ce, ee;
    logic [5:0]   idx;
    logic [127:0] data;
  } exp_t;
  exp_t         q[$];
  exp_t         mon_e;
  logic [5:0]   last_idx  = '0;
  logic [127:0] last_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC7 by textbook polynomial long division of bits hi..8 (times x^7) by 0x89
  function automatic logic [6:0] crc7_div(input logic [135:0] f, input int hi);
    logic m[0:142];
    logic [7:0] poly;
    int n;
    logic [6:0] r;
    poly = 8'h89;
    n = hi - 7;
    for (int i = 0; i < 143; i++) m[i] = 1'b0;
    for (int i = 0; i < n; i++) m[i] = f[hi - i];
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j < 8; j++) m[i + j] = m[i + j] ^ poly[7 - j];
    for (int k = 0; k < 7; k++) r[6 - k] = m[n + k];
    return r;
  endfunction

  function automatic exp_t model(input logic [135:0] f, input logic lng, input logic nc);
    exp_t e;
    logic [6:0] c;
    c      = crc7_div(f, lng ? 127 : 47);
    e.to   = 1'b0;
    e.ee   = ~f[0];
    e.ce   = !nc && (f[7:1] != c);
    e.idx  = lng ? f[133:128] : f[45:40];
    e.data = lng ? {f[127:1], 1'b0} : {96'd0, f[39:8]};
    return e;
  endfunction

  // monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && rif.done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        mon_e = q.pop_front();
        chk("timeout",    rif.timeout,    mon_e.to);
        chk("crc_err",    rif.crc_err,    mon_e.ce);
        chk("end_err",    rif.end_err,    mon_e.ee);
        chk("resp_index", rif.resp_index, mon_e.idx);
        chk("resp_data",  rif.resp_data,  mon_e.data);
        chk("busy_at_done", rif.busy,     1'b0);
      end
    end
  end

  task automatic strobe(input logic b, input logic st = 1'b0);
    repeat (gap) @(negedge clk);
    sd_cmd_i  = b;
    clk_en    = 1'b1;
    rif.start = st;
    @(negedge clk);
    clk_en    = 1'b0;
    rif.start = 1'b0;
  endtask

  task automatic arm(input logic lng, input logic nc);
    @(negedge clk);
    rif.start = 1'b1; rif.long_resp = lng; rif.no_crc = nc;
    @(negedge clk);
    rif.start = 1'b0;
    chk("busy_after_arm", rif.busy, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || rif.busy) && n < 400) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL wait_done: got busy/pending after %0d cycles expected idle", n);
    end
  endtask

  task automatic send_frame(input logic [135:0] f, input logic lng, input logic nc,
                            input int idle_n, input int glitch_at = -1);
    exp_t e;
    int len;
    len = lng ? 136 : 48;
    arm(lng, nc);
    e = model(f, lng, nc);
    last_idx = e.idx; last_data = e.data;
    q.push_back(e);
    repeat (idle_n) strobe(1'b1);
    for (int i = len - 1; i >= 0; i--) strobe(f[i], i == glitch_at);
    sd_cmd_i = 1'b1;
    wait_idle();
  endtask

  initial begin
    logic [135:0] f;
    logic [127:0] x;
    exp_t e;
    int k;
    logic seen;
    rif.start = 1'b0; rif.long_resp = 1'b0; rif.no_crc = 1'b0;
`ifdef SD_RESP_RX_R1B_EN
    rif.wait_busy = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", rif.busy, 1'b0);
    chk("rst_done", rif.done, 1'b0);
    chk("rst_timeout", rif.timeout, 1'b0);
    chk("rst_crc_err", rif.crc_err, 1'b0);
    chk("rst_end_err", rif.end_err, 1'b0);
    chk("rst_index", rif.resp_index, 6'd0);
    chk("rst_data", rif.resp_data, 128'd0);
    reset = 1'b1;

    // directed 48-bit frames: good, bad CRC, bad CRC ignored, bad end bit
    f = '0; f[47:0] = 48'h110000090067;
    e = model(f, 1'b0, 1'b0);
    chk("ref_good_crc", e.ce, 1'b0);
    send_frame(f, 1'b0, 1'b0, 5);
    f[47:0] = 48'h11000009006F; send_frame(f, 1'b0, 1'b0, 5);
    send_frame(f, 1'b0, 1'b1, 5);
    f[47:0] = 48'h110000090066; send_frame(f, 1'b0, 1'b0, 2);

    // timeout: done exactly on the NCR_MAX-th strobe
    arm(1'b0, 1'b0);
    e.to = 1'b1; e.ce = 1'b0; e.ee = 1'b0; e.idx = last_idx; e.data = last_data;
    q.push_back(e);
    k = 0; seen = 1'b0;
    while (k < 80 && !seen) begin
      strobe(1'b1); k++;
      if (rif.done) seen = 1'b1;
    end
    chk("timeout_strobes", k, 64);
    wait_idle();

    // R2 with a stray start pulse mid-frame
    x = 128'h123456789ABCDEF0_0FEDCBA987654321;
    f = {2'b00, 6'h3F, x[127:8], 7'd0, 1'b1};
    f[7:1] = crc7_div(f, 127);
    send_frame(f, 1'b1, 1'b0, 3, 60);

    // reset mid-RECV: everything clears, no done
    arm(1'b0, 1'b0);
    f = '0; f[47:0] = 48'h110000090067;
    repeat (3) strobe(1'b1);
    for (int i = 47; i >= 28; i--) strobe(f[i]);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", rif.busy, 1'b0);
    chk("midrst_done", rif.done, 1'b0);
    chk("midrst_crc_err", rif.crc_err, 1'b0);
    chk("midrst_end_err", rif.end_err, 1'b0);
    chk("midrst_index", rif.resp_index, 6'd0);
    chk("midrst_data", rif.resp_data, 128'd0);
    last_idx = '0; last_data = '0;
    sd_cmd_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(f, 1'b0, 1'b0, 4);

    // randomized frames
    for (int n = 0; n < 30; n++) begin
      logic lng, nc;
      gap = $urandom_range(0, 3);
      lng = ($urandom_range(0, 2) == 0);
      nc  = ($urandom_range(0, 3) == 0);
      f = '0;
      if (lng) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        f = {1'b0, 1'($urandom), 6'h3F, x[127:8], 7'd0, 1'b1};
        f[7:1] = crc7_div(f, 127);
      end else begin
        f[47:0] = {1'b0, 1'($urandom), 6'($urandom), 32'($urandom), 7'd0, 1'b1};
        f[7:1] = crc7_div(f, 47);
      end
      if ($urandom_range(0, 3) == 0) f[$urandom_range(1, 7)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) f[0] = 1'b0;
      send_frame(f, lng, nc, $urandom_range(0, 10));
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
